// File: rtl/fetch_instr_queue.sv
// fetch_instr_queue
//   Circular instruction queue between fetch and decode. Fetch pushes up to
//   SUPER_SCALAR_WIDTH {instr, pc} pairs per cycle. Decode sees the oldest
//   SUPER_SCALAR_WIDTH entries show-ahead and consumes every presented lane
//   when it asserts dec_ready_in. A flush (branch redirect) empties the queue.
//
// Ports
//   clk_in        clock, all state on the rising edge
//   rst_N_in      asynchronous active-low reset (control state only)
//   flush_in      discard all entries; overrides same-cycle enq/deq
//   if_valid_in   per-lane valid from fetch, lane 0 oldest, must be contiguous
//   if_instr_in   fetched instructions, one per lane
//   if_pc_in      matching PCs
//   if_ready_out  registered: a full lane group can be taken at the next edge
//   dec_valid_out lane i valid iff count_out > i
//   dec_instr_out oldest entries, lane 0 oldest; invalid lanes drive zero
//   dec_pc_out    matching PCs; invalid lanes drive zero
//   dec_ready_in  decode consumes all valid lanes at this edge
//   count_out     registered occupancy, 0..DEPTH
//   err_out       one-cycle pulse after a non-contiguous valid mask is offered
module fetch_instr_queue #(
  parameter int INSTRUCTION_WIDTH  = 32,
  parameter int SUPER_SCALAR_WIDTH = 2,
  parameter int PC_WIDTH           = 64,
  parameter int DEPTH              = 8
) (
  input  logic                                                  clk_in,
  input  logic                                                  rst_N_in,
  input  logic                                                  flush_in,
  input  logic [SUPER_SCALAR_WIDTH-1:0]                         if_valid_in,
  input  logic [SUPER_SCALAR_WIDTH-1:0][INSTRUCTION_WIDTH-1:0]  if_instr_in,
  input  logic [SUPER_SCALAR_WIDTH-1:0][PC_WIDTH-1:0]           if_pc_in,
  output logic                                                  if_ready_out,
  output logic [SUPER_SCALAR_WIDTH-1:0]                         dec_valid_out,
  output logic [SUPER_SCALAR_WIDTH-1:0][INSTRUCTION_WIDTH-1:0]  dec_instr_out,
  output logic [SUPER_SCALAR_WIDTH-1:0][PC_WIDTH-1:0]           dec_pc_out,
  input  logic                                                  dec_ready_in,
  output logic [$clog2(DEPTH+1)-1:0]                            count_out,
  output logic                                                  err_out
);

  localparam int SSW = SUPER_SCALAR_WIDTH;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);

  // Number of set lanes in a valid mask.
  function automatic logic [CW-1:0] lane_count(input logic [SSW-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < SSW; i++) begin
      if (v[i]) n++;
    end
    return CW'(n);
  endfunction

  // A mask is well formed when no valid lane sits above an invalid one.
  function automatic logic mask_contiguous(input logic [SSW-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 1; i < SSW; i++) begin
      if (v[i] && !v[i-1]) ok = 1'b0;
    end
    return ok;
  endfunction

  logic [INSTRUCTION_WIDTH-1:0] instr_mem [DEPTH];
  logic [PC_WIDTH-1:0]          pc_mem    [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          if_ready;
  logic          err;

  logic          mask_ok;
  logic          enq_fire;
  logic          deq_fire;
  logic          err_next;
  logic [CW-1:0] n_enq;
  logic [CW-1:0] n_deq;
  logic [CW-1:0] count_next;
  logic          ready_next;

  always_comb begin
    mask_ok    = mask_contiguous(if_valid_in);
    enq_fire   = if_ready && (|if_valid_in) && !flush_in && mask_ok;
    err_next   = if_ready && (|if_valid_in) && !flush_in && !mask_ok;
    deq_fire   = dec_ready_in && (count != '0) && !flush_in;
    n_enq      = enq_fire ? lane_count(if_valid_in) : '0;
    n_deq      = '0;
    if (deq_fire) n_deq = (count >= CW'(SSW)) ? CW'(SSW) : count;
    count_next = flush_in ? '0 : (count + n_enq - n_deq);
    // Conservative: only the committed occupancy is credited.
    ready_next = (count_next <= CW'(DEPTH - SSW));
  end

  // Control state: pointers, occupancy, ready and error flags.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      if_ready <= 1'b1;
      err      <= 1'b0;
    end else begin
      if (flush_in) begin
        head <= '0;
        tail <= '0;
      end else begin
        head <= head + PW'(n_deq);
        tail <= tail + PW'(n_enq);
      end
      count    <= count_next;
      if_ready <= ready_next;
      err      <= err_next;
    end
  end

  // Storage write: a well-formed mask means the valid lanes are exactly
  // lanes 0..n_enq-1, so the lane valid bit selects the slots to write.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < SSW; i++) begin
      if (enq_fire && if_valid_in[i]) begin
        instr_mem[tail + PW'(i)] <= if_instr_in[i];
        pc_mem[tail + PW'(i)]    <= if_pc_in[i];
      end
    end
  end

  // Show-ahead read of the oldest lanes; pointer arithmetic wraps naturally.
  always_comb begin
    dec_valid_out = '0;
    dec_instr_out = '0;
    dec_pc_out    = '0;
    for (int i = 0; i < SSW; i++) begin
      dec_valid_out[i] = (count > CW'(i));
      if (dec_valid_out[i]) begin
        dec_instr_out[i] = instr_mem[head + PW'(i)];
        dec_pc_out[i]    = pc_mem[head + PW'(i)];
      end
    end
  end

  assign if_ready_out = if_ready;
  assign count_out    = count;
  assign err_out      = err;

endmodule

// File: tb/tb_fetch_instr_queue.sv
module tb_fetch_instr_queue;

  localparam int IW    = 32;
  localparam int SSW   = 2;
  localparam int PCW   = 64;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic                     clk_in = 1'b0;
  logic                     rst_N_in = 1'b0;
  logic                     flush_in = 1'b0;
  logic [SSW-1:0]           if_valid_in = '0;
  logic [SSW-1:0][IW-1:0]   if_instr_in = '0;
  logic [SSW-1:0][PCW-1:0]  if_pc_in = '0;
  logic                     if_ready_out;
  logic [SSW-1:0]           dec_valid_out;
  logic [SSW-1:0][IW-1:0]   dec_instr_out;
  logic [SSW-1:0][PCW-1:0]  dec_pc_out;
  logic                     dec_ready_in = 1'b0;
  logic [CW-1:0]            count_out;
  logic                     err_out;

  fetch_instr_queue #(
    .INSTRUCTION_WIDTH(IW), .SUPER_SCALAR_WIDTH(SSW), .PC_WIDTH(PCW), .DEPTH(DEPTH)
  ) dut (
    .clk_in(clk_in), .rst_N_in(rst_N_in), .flush_in(flush_in),
    .if_valid_in(if_valid_in), .if_instr_in(if_instr_in), .if_pc_in(if_pc_in),
    .if_ready_out(if_ready_out), .dec_valid_out(dec_valid_out),
    .dec_instr_out(dec_instr_out), .dec_pc_out(dec_pc_out),
    .dec_ready_in(dec_ready_in), .count_out(count_out), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;
  logic [IW+PCW-1:0] exp_q [$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: whenever decode consumes, every presented lane must match the
  // oldest expected entry; invalid lanes must carry zero data.
  always @(negedge clk_in) begin
    if (rst_N_in && dec_ready_in && !flush_in) begin
      for (int i = 0; i < SSW; i++) begin
        if (dec_valid_out[i]) begin
          if (exp_q.size() == 0) begin
            chk("sb_underflow", 128'(exp_q.size()), 128'd1);
          end else begin
            logic [IW+PCW-1:0] e;
            e = exp_q.pop_front();
            chk("sb_instr", 128'(dec_instr_out[i]), 128'(e[IW+PCW-1:PCW]));
            chk("sb_pc", 128'(dec_pc_out[i]), 128'(e[PCW-1:0]));
          end
        end else begin
          chk("sb_idle_lane_zero", 128'(dec_instr_out[i]), 128'd0);
        end
      end
    end
  end

  // Drive one cycle of stimulus; acc says whether the group is expected to
  // enter the queue. Returns at 1ns after the consuming edge.
  task automatic drive(input logic fl, input logic [1:0] v,
                       input logic [IW-1:0] i0, input logic [PCW-1:0] p0,
                       input logic [IW-1:0] i1, input logic [PCW-1:0] p1,
                       input logic rdy, input logic acc);
    flush_in       = fl;
    if_valid_in    = v;
    if_instr_in[0] = i0;
    if_pc_in[0]    = p0;
    if_instr_in[1] = i1;
    if_pc_in[1]    = p1;
    dec_ready_in   = rdy;
    if (acc) begin
      if (v[0]) exp_q.push_back({i0, p0});
      if (v[1]) exp_q.push_back({i1, p1});
    end
    @(posedge clk_in);
    #1;
    if (fl) exp_q.delete();
    flush_in     = 1'b0;
    if_valid_in  = '0;
    dec_ready_in = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 2'b00, '0, '0, '0, '0, rdy, 1'b0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_count", 128'(count_out), 128'd0);
    chk("rst_ready", 128'(if_ready_out), 128'd1);
    chk("rst_err", 128'(err_out), 128'd0);
    chk("rst_valid", 128'(dec_valid_out), 128'd0);
    rst_N_in = 1'b1;
    @(posedge clk_in); #1;

    // First group visible one cycle after enqueue
    drive(1'b0, 2'b11, 32'h91000421, 64'h1000, 32'hF8400020, 64'h1004, 1'b0, 1'b1);
    chk("t1_valid", 128'(dec_valid_out), 128'h3);
    chk("t1_count", 128'(count_out), 128'd2);
    chk("t1_instr0", 128'(dec_instr_out[0]), 128'h91000421);
    chk("t1_pc0", 128'(dec_pc_out[0]), 128'h1000);
    chk("t1_instr1", 128'(dec_instr_out[1]), 128'hF8400020);
    chk("t1_pc1", 128'(dec_pc_out[1]), 128'h1004);

    // Fill to full with decode stalled
    for (int k = 1; k < 4; k++) begin
      drive(1'b0, 2'b11, 32'hA0000000 + 32'(2*k), 64'h1000 + 64'(8*k),
            32'hA0000001 + 32'(2*k), 64'h1004 + 64'(8*k), 1'b0, 1'b1);
    end
    chk("full_count", 128'(count_out), 128'd8);
    chk("full_ready", 128'(if_ready_out), 128'd0);
    drive(1'b0, 2'b11, 32'hDEADBEEF, 64'h9999, 32'hDEADBEEF, 64'h999C, 1'b0, 1'b0);
    chk("full_ignore_count", 128'(count_out), 128'd8);
    chk("full_ignore_err", 128'(err_out), 128'd0);
    for (int k = 0; k < 4; k++) idle(1'b1);
    chk("drain_count", 128'(count_out), 128'd0);
    chk("drain_valid", 128'(dec_valid_out), 128'd0);
    chk("drain_ready", 128'(if_ready_out), 128'd1);

    // Fill to 7, then dequeue with an offered group while not ready
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 2'b11, 32'hB0000000 + 32'(2*k), 64'h3000 + 64'(8*k),
            32'hB0000001 + 32'(2*k), 64'h3004 + 64'(8*k), 1'b0, 1'b1);
    end
    drive(1'b0, 2'b01, 32'hB0000006, 64'h3018, '0, '0, 1'b0, 1'b1);
    chk("seven_count", 128'(count_out), 128'd7);
    chk("seven_ready", 128'(if_ready_out), 128'd0);
    drive(1'b0, 2'b11, 32'hEEEE0000, 64'h7000, 32'hEEEE0001, 64'h7004, 1'b1, 1'b0);
    chk("deq_only_count", 128'(count_out), 128'd5);
    chk("deq_only_ready", 128'(if_ready_out), 128'd1);

    // Flush at count 5 with enqueue and dequeue also requested
    drive(1'b1, 2'b11, 32'hEEEE0002, 64'h7008, 32'hEEEE0003, 64'h700C, 1'b1, 1'b0);
    chk("flush_count", 128'(count_out), 128'd0);
    chk("flush_valid", 128'(dec_valid_out), 128'd0);
    chk("flush_ready", 128'(if_ready_out), 128'd1);
    drive(1'b0, 2'b01, 32'h13000001, 64'h2000, '0, '0, 1'b0, 1'b1);
    chk("post_flush_valid", 128'(dec_valid_out), 128'h1);
    chk("post_flush_instr0", 128'(dec_instr_out[0]), 128'h13000001);
    chk("post_flush_pc0", 128'(dec_pc_out[0]), 128'h2000);
    chk("post_flush_lane1_zero", 128'(dec_instr_out[1]), 128'd0);
    chk("post_flush_count", 128'(count_out), 128'd1);

    // Malformed mask pulses err once, no state change
    drive(1'b0, 2'b10, 32'h0BAD0000, 64'h5000, 32'h0BAD0001, 64'h5004, 1'b0, 1'b0);
    chk("bad_mask_err", 128'(err_out), 128'd1);
    chk("bad_mask_count", 128'(count_out), 128'd1);
    idle(1'b0);
    chk("bad_mask_err_clear", 128'(err_out), 128'd0);
    drive(1'b0, 2'b01, 32'h13000002, 64'h2004, '0, '0, 1'b0, 1'b1);
    chk("single_valid", 128'(dec_valid_out), 128'h3);
    chk("single_count", 128'(count_out), 128'd2);
    idle(1'b1);
    chk("single_drain_count", 128'(count_out), 128'd0);

    // Stream 20 instructions across pointer wrap with toggling decode ready
    begin
      int sent;
      int cyc;
      logic [1:0] v;
      sent = 0;
      cyc  = 0;
      while ((sent < 20 || exp_q.size() != 0) && cyc < 200) begin
        v = (sent < 20 && if_ready_out) ? 2'b11 : 2'b00;
        drive(1'b0, v, 32'hC0DE0000 + 32'(sent*4), 64'(sent*4),
              32'hC0DE0000 + 32'(sent*4 + 4), 64'(sent*4 + 4),
              (cyc % 3) != 2, v != 2'b00);
        if (v != 2'b00) sent += 2;
        cyc++;
      end
      chk("stream_in_budget", 128'(cyc < 200), 128'd1);
      chk("stream_count", 128'(count_out), 128'd0);
    end

    // Asynchronous reset mid-cycle clears state without a clock edge
    drive(1'b0, 2'b11, 32'h77770000, 64'h8000, 32'h77770001, 64'h8004, 1'b0, 1'b0);
    #2;
    rst_N_in = 1'b0;
    #1;
    chk("async_rst_count", 128'(count_out), 128'd0);
    chk("async_rst_valid", 128'(dec_valid_out), 128'd0);
    chk("async_rst_ready", 128'(if_ready_out), 128'd1);
    #3;
    rst_N_in = 1'b1;
    @(posedge clk_in); #1;

    chk("sb_empty_at_end", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_instr_queue.md
# fetch_instr_queue

Instruction queue between fetch and decode. Buffers fetched 32-bit instructions with their PCs in a circular FIFO, accepting up to SUPER_SCALAR_WIDTH instructions per cycle from fetch. Presents the oldest SUPER_SCALAR_WIDTH entries in order to the decode stage, which maps each instruction to an opcode_t. Absorbs decode back-pressure and is cleared on pipeline flush (branch redirect).

## Interface
- INSTRUCTION_WIDTH, 32, instruction word width
- SUPER_SCALAR_WIDTH, 2, lanes per cycle on each side (SSW)
- PC_WIDTH, 64, program counter width
- DEPTH, 8, entries; power of two, >= 2*SSW
- clk_in  in  1  clock; all state on rising edge
- rst_N_in  in  1  asynchronous, active-low reset
- flush_in  in  1  discard all entries
- if_valid_in  in  SSW  per-lane valid from fetch; lane 0 is oldest
- if_instr_in  in  SSW x INSTRUCTION_WIDTH  instructions
- if_pc_in  in  SSW x PC_WIDTH  PCs
- if_ready_out  out  1  queue can take a full SSW group next edge (registered)
- dec_valid_out  out  SSW  lane i valid iff count > i
- dec_instr_out  out  SSW x INSTRUCTION_WIDTH  oldest entries, lane 0 oldest
- dec_pc_out  out  SSW x PC_WIDTH  matching PCs
- dec_ready_in  in  1  decode consumes all valid lanes this edge
- count_out  out  $clog2(DEPTH+1)  occupied entries (registered)
- err_out  out  1  one-cycle pulse on malformed enqueue

## Operation
- Storage: DEPTH-entry array of {instr, pc}; head and tail pointers of $clog2(DEPTH) bits wrap modulo DEPTH; count register holds 0..DEPTH.
- Enqueue fires when if_ready_out && |if_valid_in && !flush_in. Valid lanes must be contiguous from lane 0 (1, 11, ...). Lane i is written at tail+i; tail advances by popcount(if_valid_in).
- Malformed valid mask (any lane valid above an invalid lane, e.g. 2'b10): whole group dropped; err_out = 1 the next cycle; no state change.
- Dequeue fires when dec_ready_in && |dec_valid_out && !flush_in. Removes all presented valid lanes (min(count, SSW)); head advances by that amount.
- Outputs are show-ahead: dec_* driven combinationally from array[head+i] and count. Lanes with dec_valid_out[i] = 0 drive zero data.
- Simultaneous enqueue and dequeue: count_next = count + n_enq - n_deq; both pointers update.
- Flush: highest priority. Same-cycle enqueue and dequeue are ignored. Next cycle: head = tail = 0, count = 0, dec_valid_out = 0. Decode must not treat flush-cycle outputs as consumed.
- if_ready_out_next = (DEPTH - count_next) >= SSW. It is conservative: it does not credit a same-cycle dequeue beyond count_next.
- Fetch driving if_valid_in while if_ready_out = 0: group ignored, no error.

## Timing
- Reset (async assert, sync-safe deassert): head = tail = count = 0, if_ready_out = 1, err_out = 0, dec_valid_out = 0, array contents don't-care.
- Enqueue-to-visible latency: 1 cycle. Entry written at edge N appears on dec_* after edge N; no same-cycle bypass.
- Dequeue: zero-cycle combinational presentation; consumption takes effect at the edge.
- Throughput: SSW in, SSW out per cycle sustained when 0 < count <= DEPTH - SSW.
- Full: count = DEPTH forces if_ready_out = 0. Also, count > DEPTH - SSW forces if_ready_out = 0.
- Empty: count = 0 gives dec_valid_out = 0; dequeue is a no-op.
- Reset asserted mid-operation clears all state immediately, independent of clk_in.

## Test plan
- Reset then enqueue {0x91000421 @ PC 0x1000, 0xF8400020 @ 0x1004} with valid 2'b11 -> next cycle dec_valid_out = 2'b11, lane0 = 0x91000421/0x1000, lane1 = 0xF8400020/0x1004, count_out = 2.
- Hold dec_ready_in = 0 and enqueue 2 per cycle -> after 4 enqueues count_out = 8, if_ready_out = 0; further fetch groups ignored; order preserved on drain.
- Fill to 7, then assert dec_ready_in plus a 2'b11 enqueue in the same cycle -> ready was 0, so only the dequeue applies; count_out = 5, if_ready_out = 1.
- Stream 20 instructions with PCs 0x0..0x4C through while toggling dec_ready_in -> PCs exit strictly increasing with no gaps across pointer wrap.
- Enqueue with if_valid_in = 2'b10 -> err_out pulses once, count_out unchanged; 2'b01 with count = 1 -> dec_valid_out = 2'b11.
- Count = 5, assert flush_in together with enqueue and dec_ready_in -> next cycle count_out = 0, dec_valid_out = 0, if_ready_out = 1; the next enqueue appears at lane 0.
